// File: rtl/mips_mem_pkg.sv
// Shared types for the load/store unit of the multicycle MIPS datapath.
// Holds the memory operation encoding, the access FSM state encoding and
// small decode helpers used by both the control path and the load extractor.
package mips_mem_pkg;

    typedef enum logic [3:0] {
        LB  = 4'd0,
        LBU = 4'd1,
        LH  = 4'd2,
        LHU = 4'd3,
        LW  = 4'd4,
        LWL = 4'd5,
        LWR = 4'd6,
        SB  = 4'd8,
        SH  = 4'd9,
        SW  = 4'd10
    } mem_op_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // True for every operation that reads memory.
    function automatic logic is_load(input mem_op_t op);
        logic res;
        case (op)
            LB, LBU, LH, LHU, LW, LWL, LWR: res = 1'b1;
            default:                        res = 1'b0;
        endcase
        return res;
    endfunction

    // True for any encoding that names a real operation (7 and 11..15 are holes).
    function automatic logic is_legal(input logic [3:0] op);
        logic res;
        case (op)
            LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW: res = 1'b1;
            default:                                    res = 1'b0;
        endcase
        return res;
    endfunction

    // Halfword ops need an even offset, word ops a zero offset; byte and
    // unaligned-word ops (LWL/LWR) accept any offset.
    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] k);
        logic res;
        case (op)
            LH, LHU, SH: res = k[0];
            LW, SW:      res = (k != 2'b00);
            default:     res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_load_extract.sv
// Combinational writeback formatter for loads.
// Ports:
//   readdata  in  32  word returned by memory (little-endian lanes)
//   k         in  2   byte offset of the original address
//   op        in  4   load operation
//   rt_prev   in  32  current rt value, merged into by LWL/LWR
//   result    out 32  value ready for register writeback
module mem_load_extract
    import mips_mem_pkg::*;
(
    input  logic [31:0] readdata,
    input  logic [1:0]  k,
    input  mem_op_t     op,
    input  logic [31:0] rt_prev,
    output logic [31:0] result
);

    logic [4:0]  lane_sh_s;
    logic [4:0]  lwl_sh_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign lane_sh_s = {k, 3'b000};
    // LWL places memory byte k at rt byte 3, i.e. shifts left by 3-k bytes.
    assign lwl_sh_s  = {2'd3 - k, 3'b000};
    assign byte_s    = readdata[lane_sh_s +: 8];
    assign half_s    = k[1] ? readdata[31:16] : readdata[15:0];

    // Select, extend or merge the returned word according to the operation.
    always_comb begin
        result = 32'd0;
        case (op)
            LB:  result = {{24{byte_s[7]}}, byte_s};
            LBU: result = {24'd0, byte_s};
            LH:  result = {{16{half_s[15]}}, half_s};
            LHU: result = {16'd0, half_s};
            LW:  result = readdata;
            // Memory bytes k..0 land in rt bytes 3..3-k; lower rt bytes survive.
            LWL: result = (readdata << lwl_sh_s) | (rt_prev & ~(32'hFFFF_FFFF << lwl_sh_s));
            // Memory bytes 3..k land in rt bytes 3-k..0; upper k rt bytes survive.
            LWR: result = (readdata >> lane_sh_s) | (rt_prev & ~(32'hFFFF_FFFF >> lane_sh_s));
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: turns an ALU byte address into one Avalon-style access.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start, mem_op, addr request handshake, op code and byte address
//   store_data, rt_prev store value and current rt (LWL/LWR merge source)
//   busy, done          not-idle flag and one-cycle completion pulse
//   addr_error          misalignment flag, valid with done
//   load_data           formatted load result, held until the next load
//   avm_*               Avalon-MM master (word address, strobes, data, stall)
// All outputs come straight from registers; nothing combinational reaches
// the bus from start.
module mem_access_unit
    import mips_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] rt_prev,
    output logic        busy,
    output logic        done,
    output logic        addr_error,
    output logic [31:0] load_data,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    state_t      state_r, state_nx;
    mem_op_t     op_r, op_nx;
    logic [1:0]  k_r, k_nx;
    logic [31:0] rt_prev_r, rt_prev_nx;
    logic        busy_r, done_r, err_r, err_nx;
    logic        rd_r, rd_nx, wr_r, wr_nx;
    logic [31:0] addr_r, addr_nx, wdata_r, wdata_nx, load_r, load_nx;
    logic [3:0]  be_r, be_nx;

    mem_op_t     req_op_s;
    logic [1:0]  req_k_s;
    logic [31:0] st_wdata_s;
    logic [3:0]  st_be_s;
    logic [31:0] extract_s;

    assign req_op_s = mem_op_t'(mem_op);
    assign req_k_s  = addr[1:0];

    mem_load_extract u_extract (
        .readdata (avm_readdata),
        .k        (k_r),
        .op       (op_r),
        .rt_prev  (rt_prev_r),
        .result   (extract_s)
    );

    // Store lane steering: replicate data across the word, enable only the target lanes.
    always_comb begin
        st_wdata_s = wdata_r;
        st_be_s    = 4'b1111;
        case (req_op_s)
            SB: begin
                st_wdata_s = {4{store_data[7:0]}};
                st_be_s    = 4'b0001 << req_k_s;
            end
            SH: begin
                st_wdata_s = {2{store_data[15:0]}};
                st_be_s    = req_k_s[1] ? 4'b1100 : 4'b0011;
            end
            SW: begin
                st_wdata_s = store_data;
                st_be_s    = 4'b1111;
            end
            default: begin
                st_wdata_s = wdata_r;
                st_be_s    = 4'b1111;
            end
        endcase
    end

    // Next-state and next-output decode; bus fields hold unless a new access starts.
    always_comb begin
        state_nx   = state_r;
        op_nx      = op_r;
        k_nx       = k_r;
        rt_prev_nx = rt_prev_r;
        err_nx     = 1'b0;
        rd_nx      = 1'b0;
        wr_nx      = 1'b0;
        addr_nx    = addr_r;
        wdata_nx   = wdata_r;
        be_nx      = be_r;
        load_nx    = load_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    op_nx      = req_op_s;
                    k_nx       = req_k_s;
                    rt_prev_nx = rt_prev;
                    if (!is_legal(mem_op)) begin
                        state_nx = S_RESP;
                    end else if (is_misaligned(req_op_s, req_k_s)) begin
                        state_nx = S_RESP;
                        err_nx   = 1'b1;
                    end else begin
                        state_nx = S_ACCESS;
                        rd_nx    = is_load(req_op_s);
                        wr_nx    = !is_load(req_op_s);
                        addr_nx  = {addr[31:2], 2'b00};
                        wdata_nx = st_wdata_s;
                        be_nx    = st_be_s;
                    end
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (!avm_waitrequest) begin
                    state_nx = S_RESP;
                    if (rd_r) begin
                        load_nx = extract_s;
                    end else begin
                        load_nx = load_r;
                    end
                end else begin
                    rd_nx = rd_r;
                    wr_nx = wr_r;
                end
            end
            S_RESP: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State and output registers; busy/done are decoded from the next state so they are registered too.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            op_r      <= LB;
            k_r       <= 2'd0;
            rt_prev_r <= 32'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            rd_r      <= 1'b0;
            wr_r      <= 1'b0;
            addr_r    <= 32'd0;
            wdata_r   <= 32'd0;
            be_r      <= 4'd0;
            load_r    <= 32'd0;
        end else begin
            state_r   <= state_nx;
            op_r      <= op_nx;
            k_r       <= k_nx;
            rt_prev_r <= rt_prev_nx;
            busy_r    <= (state_nx != S_IDLE);
            done_r    <= (state_nx == S_RESP);
            err_r     <= err_nx;
            rd_r      <= rd_nx;
            wr_r      <= wr_nx;
            addr_r    <= addr_nx;
            wdata_r   <= wdata_nx;
            be_r      <= be_nx;
            load_r    <= load_nx;
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign addr_error     = err_r;
    assign load_data      = load_r;
    assign avm_address    = addr_r;
    assign avm_read       = rd_r;
    assign avm_write      = wr_r;
    assign avm_writedata  = wdata_r;
    assign avm_byteenable = be_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a transaction-level model built
// from byte arrays is compared against the DUT every cycle, and a directed
// vector table carries hand-computed load/store/timing expectations.
module tb_mem_access_unit;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  mem_op = 4'd0;
    logic [31:0] addr = 32'd0, store_data = 32'd0, rt_prev = 32'd0;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'd0;
    logic        busy, done, addr_error, avm_read, avm_write;
    logic [31:0] load_data, avm_address, avm_writedata;
    logic [3:0]  avm_byteenable;

    mem_access_unit dut (
        .clk(clk), .reset(reset), .start(start), .mem_op(mem_op), .addr(addr),
        .store_data(store_data), .rt_prev(rt_prev), .busy(busy), .done(done),
        .addr_error(addr_error), .load_data(load_data), .avm_address(avm_address),
        .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic int op_size(input logic [3:0] op);
        if (op inside {LB, LBU, SB}) return 1;
        if (op inside {LH, LHU, SH}) return 2;
        return 4;
    endfunction

    function automatic bit m_legal(input logic [3:0] op);
        return op inside {LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW};
    endfunction

    function automatic bit m_isload(input logic [3:0] op);
        return op inside {LB, LBU, LH, LHU, LW, LWL, LWR};
    endfunction

    function automatic bit m_misal(input logic [3:0] op, input logic [31:0] a);
        if (op inside {LH, LHU, SH, LW, SW}) return (int'(a[1:0]) % op_size(op)) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input int k,
                                           input logic [31:0] rd, input logic [31:0] rt);
        logic [7:0] m[4];
        logic [7:0] r[4];
        logic [15:0] h;
        for (int i = 0; i < 4; i++) begin
            m[i] = rd[8*i +: 8];
            r[i] = rt[8*i +: 8];
        end
        h = {m[2*(k/2)+1], m[2*(k/2)]};
        case (op)
            LB:  return {{24{m[k][7]}}, m[k]};
            LBU: return {24'd0, m[k]};
            LH:  return {{16{h[15]}}, h};
            LHU: return {16'd0, h};
            LW:  return rd;
            LWL: for (int j = 0; j <= k; j++) r[3-j] = m[k-j];
            LWR: for (int j = k; j <= 3; j++) r[j-k] = m[j];
            default: return rt;
        endcase
        return {r[3], r[2], r[1], r[0]};
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] sd);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % op_size(op)) +: 8];
        return w;
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] op, input logic [1:0] kk);
        logic [3:0] be;
        int base;
        base = int'(kk) - (int'(kk) % op_size(op));
        for (int i = 0; i < 4; i++) be[i] = (i >= base) && (i < base + op_size(op));
        return be;
    endfunction

    logic        m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0, m_rd = 1'b0, m_wr = 1'b0;
    logic [31:0] m_addr = 32'd0, m_wdata_r = 32'd0, m_loadv = 32'd0, t_rt = 32'd0;
    logic [3:0]  m_ben = 4'd0, t_op = 4'd0;
    int          t_k = 0;
    bit          cmp_en = 1'b0;

    // Transaction-level view: idle -> bus phase -> response, driven by the same inputs as the DUT.
    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 0; m_done <= 0; m_err <= 0; m_rd <= 0; m_wr <= 0;
            m_addr <= 0; m_wdata_r <= 0; m_ben <= 0; m_loadv <= 0;
        end else if (m_done) begin
            m_done <= 0; m_err <= 0; m_busy <= 0;
        end else if (m_rd || m_wr) begin
            if (!avm_waitrequest) begin
                m_rd <= 0; m_wr <= 0; m_done <= 1;
                if (m_rd) m_loadv <= m_load(t_op, t_k, avm_readdata, t_rt);
            end
        end else if (!m_busy && start) begin
            t_op <= mem_op; t_k <= int'(addr[1:0]); t_rt <= rt_prev; m_busy <= 1;
            if (!m_legal(mem_op)) begin
                m_done <= 1;
            end else if (m_misal(mem_op, addr)) begin
                m_done <= 1; m_err <= 1;
            end else begin
                m_addr <= addr & 32'hFFFF_FFFC;
                if (m_isload(mem_op)) begin
                    m_rd <= 1; m_ben <= 4'hF;
                end else begin
                    m_wr <= 1; m_ben <= m_be(mem_op, addr[1:0]);
                    m_wdata_r <= m_wdata(mem_op, store_data);
                end
            end
        end
    end

    // Single per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("addr_error", {31'd0, addr_error}, {31'd0, m_err});
            chk("avm_read", {31'd0, avm_read}, {31'd0, m_rd});
            chk("avm_write", {31'd0, avm_write}, {31'd0, m_wr});
            chk("avm_address", avm_address, m_addr);
            chk("avm_writedata", avm_writedata, m_wdata_r);
            chk("avm_byteenable", {28'd0, avm_byteenable}, {28'd0, m_ben});
            chk("load_data", load_data, m_loadv);
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, sd, rt, rd;
        int          w;
        bit          poke, err;
        logic [31:0] ld, wd;
        logic [3:0]  be;
    } vec_t;

    task automatic run_op(input vec_t v);
        int done_c, strb;
        logic [31:0] s_addr, s_wd;
        logic [3:0] s_be;
        bit acc;
        done_c = 0; strb = 0; s_addr = 0; s_wd = 0; s_be = 0;
        mem_op = v.op; addr = v.a; store_data = v.sd; rt_prev = v.rt; avm_readdata = v.rd;
        start = 1'b1;
        @(posedge clk); #1;
        // Scramble request inputs so the DUT must use its captured copies.
        mem_op = 4'd7; addr = 32'hFFFF_FFFF; store_data = ~v.sd; rt_prev = ~v.rt;
        for (int c = 1; c <= 30; c++) begin
            avm_waitrequest = (c <= v.w);
            start = v.poke && (c == 1);
            if (avm_read || avm_write) begin
                strb++; s_addr = avm_address; s_wd = avm_writedata; s_be = avm_byteenable;
            end
            if (done) begin
                done_c = c;
                chk("v_addr_error", {31'd0, addr_error}, {31'd0, v.err});
                chk("v_load_data", load_data, v.ld);
                break;
            end
            @(posedge clk); #1;
        end
        acc = m_legal(v.op) && !v.err;
        chk("v_latency", done_c, acc ? 2 + v.w : 1);
        chk("v_strobe_cycles", strb, acc ? 1 + v.w : 0);
        if (acc) begin
            chk("v_bus_address", s_addr, v.a & 32'hFFFF_FFFC);
            chk("v_byteenable", {28'd0, s_be}, {28'd0, v.be});
            if (!m_isload(v.op)) chk("v_writedata", s_wd, v.wd);
        end
        start = 1'b0; avm_waitrequest = 1'b0;
        @(posedge clk); #1;
    endtask

    vec_t vecs[$];

    initial begin
        // op, addr, store_data, rt_prev, readdata, stalls, poke, err, load, wdata, be
        vecs.push_back('{LW,  32'h1000_0004, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 32'hDEAD_BEEF, 32'h0, 4'hF});
        vecs.push_back('{LB,  32'h1000_0003, 32'h0, 32'h0, 32'h80AA_BBCC, 0, 0, 0, 32'hFFFF_FF80, 32'h0, 4'hF});
        vecs.push_back('{LBU, 32'h1000_0003, 32'h0, 32'h0, 32'h80AA_BBCC, 0, 0, 0, 32'h0000_0080, 32'h0, 4'hF});
        vecs.push_back('{LH,  32'h1000_0002, 32'h0, 32'h0, 32'h8001_1234, 0, 0, 0, 32'hFFFF_8001, 32'h0, 4'hF});
        vecs.push_back('{LHU, 32'h1000_0000, 32'h0, 32'h0, 32'h8001_1234, 1, 0, 0, 32'h0000_1234, 32'h0, 4'hF});
        vecs.push_back('{SB,  32'h2000_0001, 32'h1234_5678, 32'h0, 32'h0, 3, 0, 0, 32'h0000_1234, 32'h7878_7878, 4'b0010});
        vecs.push_back('{SH,  32'h2000_0006, 32'h1234_5678, 32'h0, 32'h0, 0, 0, 0, 32'h0000_1234, 32'h5678_5678, 4'b1100});
        vecs.push_back('{SW,  32'h2000_000C, 32'hCAFE_F00D, 32'h0, 32'h0, 2, 0, 0, 32'h0000_1234, 32'hCAFE_F00D, 4'b1111});
        vecs.push_back('{LWL, 32'h3000_0001, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 0, 0, 0, 32'h2211_CCDD, 32'h0, 4'hF});
        vecs.push_back('{LWR, 32'h3000_0001, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 0, 0, 0, 32'hAA44_3322, 32'h0, 4'hF});
        vecs.push_back('{LWL, 32'h3000_0000, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 0, 0, 0, 32'h11BB_CCDD, 32'h0, 4'hF});
        vecs.push_back('{LWR, 32'h3000_0003, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 1, 0, 0, 32'hAABB_CC44, 32'h0, 4'hF});
        vecs.push_back('{LW,  32'h1000_0002, 32'h0, 32'h0, 32'h1111_1111, 0, 0, 1, 32'hAABB_CC44, 32'h0, 4'hF});
        vecs.push_back('{SH,  32'h2000_0003, 32'h5555_5555, 32'h0, 32'h0, 0, 0, 1, 32'hAABB_CC44, 32'h0, 4'hF});
        vecs.push_back('{4'd7, 32'h0000_0000, 32'h0, 32'h0, 32'h2222_2222, 0, 0, 0, 32'hAABB_CC44, 32'h0, 4'hF});
        vecs.push_back('{LHU, 32'h1000_0001, 32'h0, 32'h0, 32'h3333_3333, 0, 0, 1, 32'hAABB_CC44, 32'h0, 4'hF});
        vecs.push_back('{LB,  32'h1000_0002, 32'h0, 32'h0, 32'h80AA_BBCC, 2, 1, 0, 32'hFFFF_FFAA, 32'h0, 4'hF});
        vecs.push_back('{LH,  32'h1000_0002, 32'h0, 32'h0, 32'h7FFF_0000, 0, 0, 0, 32'h0000_7FFF, 32'h0, 4'hF});

        // Pin the model against hand-computed merges.
        chk("model_lwl", m_load(LWL, 1, 32'h4433_2211, 32'hAABB_CCDD), 32'h2211_CCDD);
        chk("model_lwr", m_load(LWR, 1, 32'h4433_2211, 32'hAABB_CCDD), 32'hAA44_3322);

        @(posedge clk); #1;
        cmp_en = 1'b1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_load_data", load_data, 32'd0);
        chk("reset_byteenable", {28'd0, avm_byteenable}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) run_op(vecs[i]);

        // Reset in the middle of a stalled read: strobe drops, no late done.
        mem_op = LW; addr = 32'h4000_0000; avm_readdata = 32'h0000_1234; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; avm_waitrequest = 1'b1;
        @(posedge clk); #1;
        chk("stall_read_high", {31'd0, avm_read}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_read_low", {31'd0, avm_read}, 32'd0);
        chk("rst_busy_low", {31'd0, busy}, 32'd0);
        chk("rst_done_low", {31'd0, done}, 32'd0);
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("no_late_done", {31'd0, done}, 32'd0);
        end

        // Reset and start together: reset wins.
        mem_op = LW; addr = 32'h4000_0000; start = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b0;
        chk("rst_start_busy", {31'd0, busy}, 32'd0);
        chk("rst_start_read", {31'd0, avm_read}, 32'd0);
        @(posedge clk); #1;

        run_op('{LW, 32'h5000_0008, 32'h0, 32'h0, 32'h0BAD_F00D, 1, 0, 0, 32'h0BAD_F00D, 32'h0, 4'hF});

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
